// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter: FSM states, transaction owner
// and the default strobe width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        LSU  = 2'd2
    } arb_owner_e;

    localparam int ARB_DATA_W = 32;
    localparam int STRB_W     = ARB_DATA_W / 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus with req/gnt/rvalid handshake; the arbiter is the
// master, the memory is the slave.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = ARB_DATA_W
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Starvation guard for mem_port_arbiter: counts consecutive LSU wins over a
// waiting fetch. Instantiated only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic flush_br,
    input  logic grant_lsu,
    input  logic grant_if,
    output logic force_if
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_r;

    // Saturating count, cleared whenever fetch is served or stops asking
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (grant_if || !if_req) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (grant_lsu && !flush_br && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign force_if = (cnt_r == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the LSU, one
// transaction in flight. Optional starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_valid,
    input  logic                 lsu_req,
    input  logic                 lsu_we,
    input  logic [ADDR_W-1:0]    lsu_addr,
    input  logic [DATA_W-1:0]    lsu_wdata,
    input  logic [DATA_W/8-1:0]  lsu_wstrb,
    output logic [DATA_W-1:0]    lsu_rdata,
    output logic                 lsu_valid,
    input  logic                 flush_br,
    output logic                 stall_fetch,
    output logic                 stall_mem,
    mem_port_arbiter_if.master   mem
);

    localparam int WSTRB_W = DATA_W / 8;

    arb_state_e           state_r;
    arb_owner_e           owner_r;
    logic                 kill_r;
    logic                 mem_req_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    logic [WSTRB_W-1:0]   mem_wstrb_r;
    logic [DATA_W-1:0]    if_rdata_r;
    logic                 if_valid_r;
    logic [DATA_W-1:0]    lsu_rdata_r;
    logic                 lsu_valid_r;

    logic                 lsu_cand_s;
    logic                 if_cand_s;
    logic                 arb_en_s;
    logic                 grant_lsu_s;
    logic                 grant_if_s;
    logic                 force_if_s;
    arb_owner_e           nxt_owner_s;
    logic                 nxt_we_s;
    logic [ADDR_W-1:0]    nxt_addr_s;
    logic [DATA_W-1:0]    nxt_wdata_s;
    logic [WSTRB_W-1:0]   nxt_wstrb_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .flush_br  (flush_br),
        .grant_lsu (grant_lsu_s),
        .grant_if  (grant_if_s),
        .force_if  (force_if_s)
    );
`else
    logic unused_starve_s;
    assign force_if_s      = 1'b0;
    assign unused_starve_s = (STARVE_MAX > 0);
`endif

    // Arbitration; a requester whose response is being returned still shows its old req
    always_comb begin
        lsu_cand_s  = lsu_req && !lsu_valid_r;
        if_cand_s   = if_req && !if_valid_r && !flush_br;
        arb_en_s    = 1'b0;
        grant_lsu_s = 1'b0;
        grant_if_s  = 1'b0;
        case (state_r)
            IDLE: arb_en_s = 1'b1;
            WAIT: begin
                arb_en_s = mem.rvalid;
                if (owner_r == LSU) begin
                    lsu_cand_s = 1'b0;
                end else begin
                    if_cand_s = 1'b0;
                end
            end
            default: arb_en_s = 1'b0;
        endcase
        if (arb_en_s && if_cand_s && (force_if_s || !lsu_cand_s)) begin
            grant_if_s = 1'b1;
        end else if (arb_en_s && lsu_cand_s) begin
            grant_lsu_s = 1'b1;
        end else begin
            grant_if_s  = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    // Bus values captured on a grant; fetches never write
    always_comb begin
        nxt_owner_s = NONE;
        nxt_we_s    = 1'b0;
        nxt_addr_s  = {ADDR_W{1'b0}};
        nxt_wdata_s = {DATA_W{1'b0}};
        nxt_wstrb_s = {WSTRB_W{1'b0}};
        if (grant_lsu_s) begin
            nxt_owner_s = LSU;
            nxt_we_s    = lsu_we;
            nxt_addr_s  = lsu_addr;
            nxt_wdata_s = lsu_wdata;
            nxt_wstrb_s = lsu_wstrb;
        end else if (grant_if_s) begin
            nxt_owner_s = IF;
            nxt_addr_s  = if_addr;
        end else begin
            nxt_owner_s = NONE;
        end
    end

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            owner_r     <= NONE;
            kill_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wstrb_r <= {WSTRB_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            if_valid_r  <= 1'b0;
            lsu_rdata_r <= {DATA_W{1'b0}};
            lsu_valid_r <= 1'b0;
        end else begin
            if_valid_r  <= 1'b0;
            lsu_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    owner_r <= NONE;
                end
                ISSUE: begin
                    if (mem.gnt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= WAIT;
                    end
                    // A flushed fetch finishes its handshake but its data is dropped
                    if (flush_br && (owner_r == IF)) begin
                        kill_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem.rvalid) begin
                        if (owner_r == LSU) begin
                            lsu_rdata_r <= mem.rdata;
                            lsu_valid_r <= 1'b1;
                        end else if (!kill_r && !flush_br) begin
                            if_rdata_r <= mem.rdata;
                            if_valid_r <= 1'b1;
                        end
                        kill_r  <= 1'b0;
                        state_r <= IDLE;
                        owner_r <= NONE;
                    end else if (flush_br && (owner_r == IF)) begin
                        kill_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    owner_r <= NONE;
                end
            endcase
            if (grant_lsu_s || grant_if_s) begin
                state_r     <= ISSUE;
                owner_r     <= nxt_owner_s;
                kill_r      <= 1'b0;
                mem_req_r   <= 1'b1;
                mem_we_r    <= nxt_we_s;
                mem_addr_r  <= nxt_addr_s;
                mem_wdata_r <= nxt_wdata_s;
                mem_wstrb_r <= nxt_wstrb_s;
            end
        end
    end

    assign mem.req   = mem_req_r;
    assign mem.we    = mem_we_r;
    assign mem.addr  = mem_addr_r;
    assign mem.wdata = mem_wdata_r;
    assign mem.wstrb = mem_wstrb_r;

    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign lsu_rdata = lsu_rdata_r;
    assign lsu_valid = lsu_valid_r;

    // Stalls depend only on requests and registered valids, never on mem_rdata
    assign stall_fetch = !rst && if_req && !if_valid_r;
    assign stall_mem   = !rst && lsu_req && !lsu_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder model checks bus
// transactions in expected order, a monitor checks IF/LSU responses.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               if_req;
    logic [31:0]        if_addr;
    logic [31:0]        if_rdata;
    logic               if_valid;
    logic               lsu_req;
    logic               lsu_we;
    logic [31:0]        lsu_addr;
    logic [31:0]        lsu_wdata;
    logic [STRB_W-1:0]  lsu_wstrb;
    logic [31:0]        lsu_rdata;
    logic               lsu_valid;
    logic               flush_br;
    logic               stall_fetch;
    logic               stall_mem;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_txn_t;

    bus_txn_t    bus_q[$];
    logic [31:0] if_q[$];
    logic [31:0] lsu_q[$];
    int          gnt_delay = 1;
    int          rv_delay  = 2;
    int          checks_cnt = 0;
    int          fail_cnt   = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .lsu_req     (lsu_req),
        .lsu_we      (lsu_we),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_wstrb   (lsu_wstrb),
        .lsu_rdata   (lsu_rdata),
        .lsu_valid   (lsu_valid),
        .flush_br    (flush_br),
        .stall_fetch (stall_fetch),
        .stall_mem   (stall_mem),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_2000: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Memory model: grants after gnt_delay cycles, answers rv_delay cycles after gnt
    initial begin : responder
        int          gnt_wait;
        int          rv_cnt;
        bit          busy;
        logic [31:0] rv_data;
        bus_txn_t    t;
        gnt_wait = 0;
        rv_cnt   = 0;
        rv_data  = 32'h0;
        mem_bus.gnt    = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            mem_bus.gnt    = 1'b0;
            mem_bus.rvalid = 1'b0;
            if (rst) begin
                gnt_wait = 0;
                rv_cnt   = 0;
            end else begin
                busy = (rv_cnt > 0);
                if (busy) begin
                    check_val("bus_req_drop", 32'(mem_bus.req), 32'd0);
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mem_bus.rvalid = 1'b1;
                        mem_bus.rdata  = rv_data;
                    end
                end
                if (mem_bus.req && !busy) begin
                    check_val("bus_txn_expected", 32'(bus_q.size() > 0), 32'd1);
                    if (bus_q.size() > 0) begin
                        if (gnt_wait >= gnt_delay) begin
                            t = bus_q.pop_front();
                            check_val("bus_addr", mem_bus.addr, t.addr);
                            check_val("bus_we", 32'(mem_bus.we), 32'(t.we));
                            if (t.we) begin
                                check_val("bus_wdata", mem_bus.wdata, t.wdata);
                                check_val("bus_wstrb", 32'(mem_bus.wstrb), 32'(t.wstrb));
                            end
                            mem_bus.gnt = 1'b1;
                            gnt_wait    = 0;
                            rv_cnt      = rv_delay;
                            rv_data     = mem_model(mem_bus.addr);
                        end else begin
                            check_val("bus_hold_addr", mem_bus.addr, bus_q[0].addr);
                            gnt_wait++;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: every valid pulse must match the next expected response
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (if_valid) begin
                check_val("if_resp_expected", 32'(if_q.size() > 0), 32'd1);
                if (if_q.size() > 0) check_val("if_rdata", if_rdata, if_q.pop_front());
            end
            if (lsu_valid) begin
                check_val("lsu_resp_expected", 32'(lsu_q.size() > 0), 32'd1);
                if (lsu_q.size() > 0) check_val("lsu_rdata", lsu_rdata, lsu_q.pop_front());
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr);
        bit done;
        done    = 1'b0;
        if_addr = addr;
        if_req  = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (if_valid) begin
                check_val("stall_fetch_release", 32'(stall_fetch), 32'd0);
                done = 1'b1;
            end else begin
                check_val("stall_fetch_hold", 32'(stall_fetch), 32'd1);
            end
        end
        check_val("fetch_done", 32'(done), 32'd1);
        if_req = 1'b0;
    endtask

    task automatic do_lsu(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit chk_b2b, input logic [31:0] b2b_addr);
        bit done;
        done      = 1'b0;
        lsu_we    = we;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_wstrb = wstrb;
        lsu_req   = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (lsu_valid) begin
                check_val("stall_mem_release", 32'(stall_mem), 32'd0);
                if (chk_b2b) begin
                    check_val("b2b_req", 32'(mem_bus.req), 32'd1);
                    check_val("b2b_addr", mem_bus.addr, b2b_addr);
                end
                done = 1'b1;
            end else begin
                check_val("stall_mem_hold", 32'(stall_mem), 32'd1);
            end
        end
        check_val("lsu_done", 32'(done), 32'd1);
        lsu_req = 1'b0;
    endtask

    initial begin : main
        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0;
        lsu_req   = 1'b1;
        lsu_we    = 1'b0;
        lsu_addr  = 32'h0;
        lsu_wdata = 32'h0;
        lsu_wstrb = 4'h0;
        flush_br  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_mem_req", 32'(mem_bus.req), 32'd0);
        check_val("rst_mem_addr", mem_bus.addr, 32'd0);
        check_val("rst_mem_wstrb", 32'(mem_bus.wstrb), 32'd0);
        check_val("rst_if_valid", 32'(if_valid), 32'd0);
        check_val("rst_lsu_valid", 32'(lsu_valid), 32'd0);
        check_val("rst_if_rdata", if_rdata, 32'd0);
        check_val("rst_lsu_rdata", lsu_rdata, 32'd0);
        check_val("rst_stall_fetch", 32'(stall_fetch), 32'd0);
        check_val("rst_stall_mem", 32'(stall_mem), 32'd0);
        check_val("rst_state", 32'(dut.state_r), 32'(IDLE));
        check_val("rst_owner", 32'(dut.owner_r), 32'(NONE));
        if_req  = 1'b0;
        lsu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Lone fetch
        gnt_delay = 1;
        rv_delay  = 2;
        bus_q.push_back('{32'h100, 1'b0, 32'h0, 4'h0});
        if_q.push_back(32'h0050_0093);
        do_fetch(32'h100);
        repeat (2) @(negedge clk);

        // Simultaneous requests: LSU first, fetch issued on the load's rvalid
        bus_q.push_back('{32'h2000, 1'b0, 32'h0, 4'h0});
        bus_q.push_back('{32'h104, 1'b0, 32'h0, 4'h0});
        lsu_q.push_back(32'hDEAD_BEEF);
        if_q.push_back(mem_model(32'h104));
        fork
            do_lsu(1'b0, 32'h2000, 32'h0, 4'h0, 1'b1, 32'h104);
            do_fetch(32'h104);
        join
        repeat (2) @(negedge clk);

        // Store with a slow grant
        gnt_delay = 3;
        rv_delay  = 1;
        bus_q.push_back('{32'h2004, 1'b1, 32'h1234_5678, 4'b0011});
        lsu_q.push_back(mem_model(32'h2004));
        do_lsu(1'b1, 32'h2004, 32'h1234_5678, 4'b0011, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // Flush kill while the fetch is in WAIT, then redirect to 0x200
        gnt_delay = 1;
        rv_delay  = 3;
        bus_q.push_back('{32'h180, 1'b0, 32'h0, 4'h0});
        bus_q.push_back('{32'h200, 1'b0, 32'h0, 4'h0});
        if_q.push_back(mem_model(32'h200));
        if_addr = 32'h180;
        if_req  = 1'b1;
        for (int i = 0; i < 20 && dut.state_r != WAIT; i++) @(negedge clk);
        check_val("flush_reach_wait", 32'(dut.state_r), 32'(WAIT));
        flush_br = 1'b1;
        if_addr  = 32'h200;
        @(negedge clk);
        flush_br = 1'b0;
        check_val("flush_kill_set", 32'(dut.kill_r), 32'd1);
        do_fetch(32'h200);
        repeat (2) @(negedge clk);

        // Flush in IDLE blocks the fetch grant for that cycle
        gnt_delay = 0;
        rv_delay  = 1;
        bus_q.push_back('{32'h300, 1'b0, 32'h0, 4'h0});
        if_q.push_back(mem_model(32'h300));
        if_addr  = 32'h300;
        if_req   = 1'b1;
        flush_br = 1'b1;
        @(negedge clk);
        check_val("flush_idle_block", 32'(mem_bus.req), 32'd0);
        flush_br = 1'b0;
        do_fetch(32'h300);
        repeat (2) @(negedge clk);

        // Reset in ISSUE
        gnt_delay = 6;
        bus_q.push_back('{32'h2008, 1'b0, 32'h0, 4'h0});
        lsu_we   = 1'b0;
        lsu_addr = 32'h2008;
        lsu_req  = 1'b1;
        for (int i = 0; i < 20 && dut.state_r != ISSUE; i++) @(negedge clk);
        check_val("rstmid_reach_issue", 32'(dut.state_r), 32'(ISSUE));
        rst = 1'b1;
        @(negedge clk);
        check_val("rstmid_mem_req", 32'(mem_bus.req), 32'd0);
        check_val("rstmid_if_valid", 32'(if_valid), 32'd0);
        check_val("rstmid_lsu_valid", 32'(lsu_valid), 32'd0);
        check_val("rstmid_stall_fetch", 32'(stall_fetch), 32'd0);
        check_val("rstmid_stall_mem", 32'(stall_mem), 32'd0);
        check_val("rstmid_state", 32'(dut.state_r), 32'(IDLE));
        lsu_req = 1'b0;
        bus_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Recovery load after reset
        gnt_delay = 0;
        rv_delay  = 1;
        bus_q.push_back('{32'h2008, 1'b0, 32'h0, 4'h0});
        lsu_q.push_back(mem_model(32'h2008));
        do_lsu(1'b0, 32'h2008, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);

        check_val("end_bus_q_empty", 32'(bus_q.size()), 32'd0);
        check_val("end_if_q_empty", 32'(if_q.size()), 32'd0);
        check_val("end_lsu_q_empty", 32'(lsu_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
